// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Fetch-side next-PC predictor. A direct-mapped BTB with a 2-bit saturating
//   counter per entry is looked up combinationally with the fetch PC and
//   trained by every instruction resolving in execute. A registered redirect
//   is raised one cycle after execute finds that the carried prediction
//   differs from the resolved next PC.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   if_valid, if_pc   fetch lookup request
//   pred_taken,
//   pred_pc           combinational prediction for if_pc
//   ex_valid, ex_pc,
//   ex_is_branch,
//   ex_taken,
//   ex_target,
//   ex_pred_pc        resolved instruction from execute (training input)
//   redirect_valid,
//   redirect_pc       registered mispredict flush request and correct PC
// ---------------------------------------------------------------------------
module branch_predictor #(
   parameter int ENTRIES = 64,
   parameter int PC_W    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [PC_W-1:0] if_pc,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_pc,
   input  logic            ex_valid,
   input  logic [PC_W-1:0] ex_pc,
   input  logic            ex_is_branch,
   input  logic            ex_taken,
   input  logic [PC_W-1:0] ex_target,
   input  logic [PC_W-1:0] ex_pred_pc,
   output logic            redirect_valid,
   output logic [PC_W-1:0] redirect_pc
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

   // Table storage. Only valid and ctr need a reset value; tag and target
   // are don't-care while valid is low.
   logic             valid_q  [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [PC_W-1:0]  target_q [ENTRIES];

   logic            redirect_valid_q;
   logic [PC_W-1:0] redirect_pc_q;

   // Fetch lookup
   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;

   assign if_idx = if_pc[IDX_W+1:2];
   assign if_tag = if_pc[PC_W-1:IDX_W+2];
   assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

   assign pred_taken = if_valid && if_hit && ctr_q[if_idx][1];
   assign pred_pc    = pred_taken ? target_q[if_idx] : (if_pc + PC_STEP);

   // Execute resolution and training decode
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;
   logic [PC_W-1:0]  ex_act_pc;
   logic             mispredict;

   logic             upd_en;
   logic             tgt_en;
   logic             valid_d;
   logic [1:0]       ctr_d;

   assign ex_idx     = ex_pc[IDX_W+1:2];
   assign ex_tag     = ex_pc[PC_W-1:IDX_W+2];
   assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign ex_act_pc  = (ex_is_branch && ex_taken) ? ex_target : (ex_pc + PC_STEP);
   assign mispredict = ex_valid && (ex_pred_pc != ex_act_pc);

   always_comb begin
      upd_en  = 1'b0;
      tgt_en  = 1'b0;
      valid_d = valid_q[ex_idx];
      ctr_d   = ctr_q[ex_idx];
      if (ex_valid) begin
         if (ex_is_branch) begin
            if (ex_hit) begin
               upd_en  = 1'b1;
               valid_d = 1'b1;
               if (ex_taken) begin
                  tgt_en = 1'b1;
                  if (ctr_q[ex_idx] != 2'b11) ctr_d = ctr_q[ex_idx] + 2'd1;
               end else begin
                  if (ctr_q[ex_idx] != 2'b00) ctr_d = ctr_q[ex_idx] - 2'd1;
               end
            end else if (ex_taken) begin
               // Allocation overwrites whatever lived at this index.
               upd_en  = 1'b1;
               tgt_en  = 1'b1;
               valid_d = 1'b1;
               ctr_d   = 2'b10;
            end
         end else if (ex_hit) begin
            // A non-branch matched an entry: the entry is stale, drop it.
            upd_en  = 1'b1;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         if (upd_en) begin
            valid_q[ex_idx] <= valid_d;
            ctr_q[ex_idx]   <= ctr_d;
         end
         redirect_valid_q <= mispredict;
         if (mispredict) redirect_pc_q <= ex_act_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && tgt_en) begin
         tag_q[ex_idx]    <= ex_tag;
         target_q[ex_idx] <= ex_target;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch predictor: the consumer of the branch unit's resolved outcome (actual taken/next PC) and the producer of the next-PC guess used by instruction fetch. It holds a direct-mapped branch target buffer with a 2-bit saturating counter per entry, predicts in the same cycle as the fetch PC, and trains on every resolved instruction reported by execute. It compares the execute-stage prediction against the resolved next PC and issues a registered redirect on mismatch, which fetch uses to flush and restart.

## Interface
- ENTRIES, 64: BTB/counter entries; power of two, ≥4.
- PC_W, 32: PC and target width.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch PC valid this cycle.
- if_pc  in  PC_W  fetch PC (word aligned).
- pred_taken  out  1  predicted taken for if_pc.
- pred_pc  out  PC_W  predicted next fetch PC.
- ex_valid  in  1  an instruction resolves in execute this cycle.
- ex_pc  in  PC_W  PC of the resolving instruction.
- ex_is_branch  in  1  instruction is a branch or jump (branch unit op not NOP).
- ex_taken  in  1  resolved taken (always 1 for jumps).
- ex_target  in  PC_W  resolved taken target.
- ex_pred_pc  in  PC_W  pred_pc carried down the pipe with this instruction.
- redirect_valid  out  1  registered mispredict flush request.
- redirect_pc  out  PC_W  registered correct next PC.

## Operation
- Index = pc[log2(ENTRIES)+1:2]; tag = pc[PC_W-1:log2(ENTRIES)+2]. Entry = {valid, tag, target, ctr[1:0]}.
- Lookup (combinational from registered table): hit = valid && tag match. pred_taken = if_valid && hit && ctr[1]. pred_pc = pred_taken ? target : if_pc + 4 (mod 2^PC_W). if_valid=0 -> pred_taken=0, pred_pc=if_pc+4.
- Actual next PC: act = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 4.
- Mispredict = ex_valid && (ex_pred_pc != act). Next cycle: redirect_valid=1, redirect_pc=act; otherwise redirect_valid=0, redirect_pc holds last value.
- Training on ex_valid, indexed by ex_pc:
  - branch, hit: ctr saturating ±1 (taken inc to max 3, not taken dec to min 0); taken also rewrites target.
  - branch, miss, taken: allocate (overwrite): valid=1, tag, target=ex_target, ctr=2'b10.
  - branch, miss, not taken: no change.
  - non-branch, hit (alias): clear valid.
  - non-branch, miss: no change.
- Table write occurs on the clock edge; a lookup of the same index in the same cycle sees the old contents.
- Redirect does not alter table state beyond the normal training above.

## Timing
- Prediction: 0-cycle latency, combinational from if_pc.
- Training: visible to lookups 1 cycle after ex_valid.
- Redirect: redirect_valid asserted exactly 1 cycle after the mispredicting ex_valid, for 1 cycle per mispredict; back-to-back mispredicts give back-to-back redirect pulses.
- Reset (sampled on rising edge, any time, including mid-training): all valid=0, all ctr=2'b01, redirect_valid=0, redirect_pc=0; ex update in the reset cycle is discarded. After reset every lookup returns pred_taken=0, pred_pc=if_pc+4.
- Wrap-around: if_pc=0xFFFFFFFC -> pred_pc=0x00000000 on miss.

## Test plan
- Reset then if_pc=0x100, if_valid=1 -> pred_taken=0, pred_pc=0x104; redirect_valid=0.
- ex branch pc=0x100 taken target=0x80, ex_pred_pc=0x104 -> next cycle redirect_valid=1, redirect_pc=0x80; lookup 0x100 -> pred_taken=1, pred_pc=0x80 (ctr=2).
- Same branch not taken twice (ex_pred_pc matching prediction first time 0x80) -> first: redirect to 0x104, ctr 2->1; second: no redirect, ctr 1->0; lookup predicts 0x104. Four taken resolves saturate ctr at 3.
- Alias: entry at 0x100 taken; ex non-branch pc=0x100+ENTRIES*4 with ex_pred_pc=0x104+ENTRIES*4 -> no redirect, entry unchanged; alias pc with matching tag path (same pc, non-branch, ex_pred_pc=0x80) -> redirect to pc+4, entry invalidated.
- Same-cycle read/write: ex allocate at index of if_pc in the same cycle -> that cycle predicts miss, next cycle hit.
- Reset asserted in the cycle of a mispredicting ex_valid -> next cycle redirect_valid=0, table empty.
